// File: rtl/drbg_ks_pkg.sv
// Shared word width, slice-count helper and request FSM encoding for the
// DRBG keystream slicer.
package drbg_ks_pkg;

  localparam int unsigned DRBG_WORD_W = 256;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StGap
  } drbg_ks_state_e;

  function automatic int unsigned slices_per_word(input int unsigned out_width);
    return DRBG_WORD_W / out_width;
  endfunction

endpackage

// File: rtl/ks_word_fifo.sv
// Small synchronous FIFO of 256-bit DRBG words with flush, head and occupancy outputs.
module ks_word_fifo
  import drbg_ks_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           push,
  input  logic [DRBG_WORD_W-1:0]         push_data,
  input  logic                           pop,
  input  logic                           flush,
  output logic [DRBG_WORD_W-1:0]         head,
  output logic [$clog2(DEPTH + 1)-1:0]   count,
  output logic                           empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DRBG_WORD_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]        wr_ptr_q;
  logic [PtrW-1:0]        rd_ptr_q;
  logic [CntW-1:0]        count_q;
  logic                   do_push;
  logic                   do_pop;

  // Flush wins over both ends of the queue.
  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush & (count_q != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!do_push && do_pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/drbg_keystream_slicer.sv
// Requests words from the hash DRBG, buffers them and serves OUT_WIDTH-bit keystream slices.
// Optional KS_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module drbg_keystream_slicer
  import drbg_ks_pkg::*;
#(
  parameter int unsigned OUT_WIDTH  = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   drbg_init_ready,
  input  logic                   drbg_busy,
  output logic                   drbg_next_bits,
  input  logic                   drbg_next_bits_ready,
  input  logic [DRBG_WORD_W-1:0] drbg_random_bits,
  input  logic                   flush,
  output logic                   ks_valid,
  input  logic                   ks_ready,
  output logic [OUT_WIDTH-1:0]   ks_data,
  output logic [31:0]            words_consumed
`ifdef KS_UNDERRUN_CNT_EN
  ,
  output logic [15:0]            underrun_cnt
`endif
);

  localparam int unsigned SPW  = slices_per_word(OUT_WIDTH);
  localparam int unsigned IdxW = (SPW > 1) ? $clog2(SPW) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(SPW - 1);

  drbg_ks_state_e state_q;
  logic           nbr_q;
  logic           pending_q;
  logic           discard_q;
  logic           capture;
  logic           accept;
  logic           push;
  logic           pop;
  logic           advance;
  logic           last_slice;
  logic           can_req;
  logic           fifo_empty;
  logic [CntW-1:0]        fifo_count;
  logic [DRBG_WORD_W-1:0] head;
  logic [SPW-1:0][OUT_WIDTH-1:0] head_slices;
  logic [IdxW-1:0]        idx_q;
  logic [OUT_WIDTH-1:0]   slice;
  logic [OUT_WIDTH-1:0]   last_q;

  assign capture = drbg_next_bits_ready & ~nbr_q;
  assign accept  = capture & pending_q;
  assign push    = accept & ~discard_q & ~flush;

  // Only one request may be in flight, so with none pending the free-slot test is plain occupancy.
  assign can_req = drbg_init_ready & ~drbg_busy & ~pending_q
                 & (fifo_count < CntW'(FIFO_DEPTH));

  ks_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (drbg_random_bits),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      drbg_next_bits <= 1'b0;
      nbr_q          <= 1'b0;
      pending_q      <= 1'b0;
      discard_q      <= 1'b0;
    end else begin
      nbr_q <= drbg_next_bits_ready;
      if (accept) pending_q <= 1'b0;
      // A word still in flight at flush belongs to the old frame; one arriving now is dropped anyway.
      if (flush) begin
        discard_q <= pending_q & ~capture;
      end else if (accept) begin
        discard_q <= 1'b0;
      end
      unique case (state_q)
        StIdle, StGap: begin
          if (can_req) begin
            state_q        <= StReq;
            drbg_next_bits <= 1'b1;
            pending_q      <= 1'b1;
          end else begin
            state_q <= StIdle;
          end
        end
        StReq: begin
          if (capture) begin
            state_q        <= StGap;
            drbg_next_bits <= 1'b0;
          end else if (!drbg_init_ready) begin
            state_q        <= StIdle;
            drbg_next_bits <= 1'b0;
          end
        end
        default: begin
          state_q        <= StIdle;
          drbg_next_bits <= 1'b0;
        end
      endcase
    end
  end

  assign head_slices = head;
  assign slice       = head_slices[idx_q];
  assign ks_valid    = ~fifo_empty;
  assign ks_data     = ks_valid ? slice : last_q;
  assign last_slice  = (idx_q == LastIdx);
  assign advance     = ks_valid & ks_ready & ~flush;
  assign pop         = advance & last_slice;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q          <= '0;
      last_q         <= '0;
      words_consumed <= '0;
    end else begin
      if (ks_valid) last_q <= slice;
      if (flush) begin
        idx_q <= '0;
      end else if (advance) begin
        idx_q <= last_slice ? '0 : idx_q + 1'b1;
      end
      if (pop) words_consumed <= words_consumed + 32'd1;
    end
  end

`ifdef KS_UNDERRUN_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underrun_cnt <= '0;
    end else if (flush) begin
      underrun_cnt <= '0;
    end else if (ks_ready && !ks_valid && underrun_cnt != 16'hFFFF) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_drbg_keystream_slicer.sv
// Bench for drbg_keystream_slicer: behavioural DRBG responder plus word-queue keystream model.
module tb_drbg_keystream_slicer;

  localparam int unsigned W     = 32;
  localparam int unsigned SPW   = 256 / W;
  localparam int unsigned DEPTH = 2;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           drbg_init_ready = 1'b0;
  logic           drbg_busy = 1'b0;
  logic           drbg_next_bits;
  logic           drbg_next_bits_ready;
  logic [255:0]   drbg_random_bits;
  logic           flush = 1'b0;
  logic           ks_valid;
  logic           ks_ready = 1'b0;
  logic [W-1:0]   ks_data;
  logic [31:0]    words_consumed;
`ifdef KS_UNDERRUN_CNT_EN
  logic [15:0]    underrun_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  drbg_keystream_slicer #(
    .OUT_WIDTH  (W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .drbg_init_ready      (drbg_init_ready),
    .drbg_busy            (drbg_busy),
    .drbg_next_bits       (drbg_next_bits),
    .drbg_next_bits_ready (drbg_next_bits_ready),
    .drbg_random_bits     (drbg_random_bits),
    .flush                (flush),
    .ks_valid             (ks_valid),
    .ks_ready             (ks_ready),
    .ks_data              (ks_data),
    .words_consumed       (words_consumed)
`ifdef KS_UNDERRUN_CNT_EN
    ,
    .underrun_cnt         (underrun_cnt)
`endif
  );

  // DRBG responder: one generate per request, answered after 'lat' cycles with a one-cycle pulse.
  int           lat = 3;
  logic         gen_busy;
  logic         served;
  int           gen_cnt;
  int           words_made;
  logic [255:0] base_word;

  function automatic logic [255:0] rand_word();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gen_busy             <= 1'b0;
      served               <= 1'b0;
      gen_cnt              <= 0;
      words_made           <= 0;
      drbg_next_bits_ready <= 1'b0;
      drbg_random_bits     <= '0;
    end else begin
      drbg_next_bits_ready <= 1'b0;
      if (!drbg_next_bits) served <= 1'b0;
      if (gen_busy) begin
        if (gen_cnt <= 1) begin
          drbg_next_bits_ready <= 1'b1;
          drbg_random_bits     <= (words_made == 0) ? base_word : rand_word();
          words_made           <= words_made + 1;
          gen_busy             <= 1'b0;
          served               <= 1'b1;
        end else begin
          gen_cnt <= gen_cnt - 1;
        end
      end else if (drbg_next_bits && !served) begin
        gen_busy <= 1'b1;
        gen_cnt  <= lat;
      end
    end
  end

  // Reference model: queue of words owed to the consumer, sampled mid-cycle.
  logic [255:0] exp_q[$];
  logic [255:0] dlog[$];
  logic [W-1:0] seen[$];
  logic [255:0] cur;
  int   exp_sc, exp_consumed, reqs, deliv, gap_cycles, exp_under;
  logic drop_next, prev_nb, ev;
  logic mon_en = 1'b0;

  always begin
    @(negedge clk);
    #2;
    if (mon_en) begin
      ev = (exp_q.size() != 0);
      total++;
      if (ks_valid !== ev) begin
        bad++;
        $display("FAIL ks_valid: got %b want %b at %0t", ks_valid, ev, $time);
      end
      if (ev) begin
        cur = exp_q[0];
        total++;
        if (ks_data !== cur[exp_sc*W +: W]) begin
          bad++;
          $display("FAIL ks_data: got %h want %h at %0t", ks_data, cur[exp_sc*W +: W], $time);
        end
      end
      total++;
      if (words_consumed !== 32'(exp_consumed)) begin
        bad++;
        $display("FAIL words_consumed: got %0d want %0d at %0t", words_consumed, exp_consumed,
                 $time);
      end
`ifdef KS_UNDERRUN_CNT_EN
      total++;
      if (underrun_cnt !== 16'(exp_under)) begin
        bad++;
        $display("FAIL underrun_cnt: got %0d want %0d at %0t", underrun_cnt, exp_under, $time);
      end
`endif
      if (drbg_next_bits && !prev_nb) reqs++;
      prev_nb = drbg_next_bits;
      total++;
      if (reqs - deliv > 1) begin
        bad++;
        $display("FAIL outstanding: got %0d requests open want <=1 at %0t", reqs - deliv, $time);
      end
      if (flush) begin
        exp_q.delete();
        exp_sc    = 0;
        exp_under = 0;
        drop_next = gen_busy || (drbg_next_bits && !served);
      end else begin
        if (ev && ks_ready) begin
          seen.push_back(ks_data);
          if (exp_sc == int'(SPW) - 1) begin
            exp_sc = 0;
            void'(exp_q.pop_front());
            exp_consumed++;
          end else begin
            exp_sc++;
          end
        end
        if (ks_ready && !ev) begin
          gap_cycles++;
          if (exp_under < 65535) exp_under++;
        end
      end
      if (drbg_next_bits_ready) begin
        deliv++;
        dlog.push_back(drbg_random_bits);
        if (!flush) begin
          if (drop_next) drop_next = 1'b0;
          else exp_q.push_back(drbg_random_bits);
        end
      end
    end
  end

  task automatic do_reset();
    mon_en          = 1'b0;
    reset_n         = 1'b0;
    ks_ready        = 1'b0;
    flush           = 1'b0;
    drbg_init_ready = 1'b0;
    drbg_busy       = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    dlog.delete();
    seen.delete();
    exp_sc = 0; exp_consumed = 0; reqs = 0; deliv = 0; gap_cycles = 0; exp_under = 0;
    drop_next = 1'b0;
    prev_nb   = 1'b0;
    reset_n   = 1'b1;
    mon_en    = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total += 4;
    if (drbg_next_bits !== 1'b0) begin bad++; $display("FAIL rst_next_bits: got %b want 0", drbg_next_bits); end
    if (ks_valid !== 1'b0) begin bad++; $display("FAIL rst_ks_valid: got %b want 0", ks_valid); end
    if (ks_data !== '0) begin bad++; $display("FAIL rst_ks_data: got %h want 0", ks_data); end
    if (words_consumed !== 32'd0) begin bad++; $display("FAIL rst_words: got %0d want 0", words_consumed); end
    repeat (6) @(negedge clk);
    total++;
    if (deliv != 0 || drbg_next_bits !== 1'b0) begin
      bad++;
      $display("FAIL no_init_request: got next_bits=%b deliveries=%0d want 0/0", drbg_next_bits, deliv);
    end
  endtask

  task automatic test_byte_pattern();
    logic [W-1:0] want;
    do_reset();
    lat = 3;
    drbg_init_ready = 1'b1;
    ks_ready = 1'b1;
    for (int n = 0; n < 200 && seen.size() < SPW; n++) @(negedge clk);
    ks_ready = 1'b0;
    if (seen.size() < SPW) begin
      total++; bad++;
      $display("FAIL pattern_timeout: got %0d slices want %0d", seen.size(), SPW);
    end else begin
      for (int i = 0; i < int'(SPW); i++) begin
        want = 32'h03020100 + 32'(i) * 32'h04040404;
        total++;
        if (seen[i] !== want) begin
          bad++;
          $display("FAIL pattern_slice%0d: got %h want %h", i, seen[i], want);
        end
      end
    end
    #1;
    total++;
    if (words_consumed !== 32'd1) begin
      bad++;
      $display("FAIL pattern_words: got %0d want 1", words_consumed);
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    lat = 2;
    drbg_init_ready = 1'b1;
    repeat (150) @(negedge clk);
    total += 2;
    if (deliv != int'(DEPTH)) begin
      bad++;
      $display("FAIL bp_captures: got %0d want %0d", deliv, DEPTH);
    end
    if (drbg_next_bits !== 1'b0) begin
      bad++;
      $display("FAIL bp_next_bits: got %b want 0", drbg_next_bits);
    end
    ks_ready = 1'b1;
    repeat (60) @(negedge clk);
    ks_ready = 1'b0;
    total++;
    if (exp_consumed < 2) begin
      bad++;
      $display("FAIL bp_drain: got %0d words want >=2", exp_consumed);
    end
  endtask

  task automatic test_latency_gaps();
    do_reset();
    lat = 20;
    drbg_init_ready = 1'b1;
    ks_ready = 1'b1;
    repeat (400) @(negedge clk);
    ks_ready = 1'b0;
    total += 2;
    if (gap_cycles == 0) begin
      bad++;
      $display("FAIL lat_gaps: got %0d gap cycles want >0", gap_cycles);
    end
    if (words_consumed < 32'd10) begin
      bad++;
      $display("FAIL lat_words: got %0d want >=10", words_consumed);
    end
`ifdef KS_UNDERRUN_CNT_EN
    total++;
    if (underrun_cnt !== 16'(gap_cycles)) begin
      bad++;
      $display("FAIL lat_underrun: got %0d want %0d", underrun_cnt, gap_cycles);
    end
`endif
  endtask

  task automatic test_flush();
    int n;
    do_reset();
    lat = 10;
    drbg_init_ready = 1'b1;
    for (n = 0; n < 200 && !(deliv >= 1 && gen_busy); n++) @(negedge clk);
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL flush_setup_timeout: got deliveries=%0d want 1 plus in flight", deliv);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    total++;
    if (ks_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_valid: got %b want 0", ks_valid);
    end
    ks_ready = 1'b1;
    for (n = 0; n < 200 && seen.size() == 0; n++) @(negedge clk);
    total++;
    if (seen.size() == 0) begin
      bad++;
      $display("FAIL flush_timeout: got no slice want one");
    end else if (seen[0] !== dlog[2][W-1:0]) begin
      bad++;
      $display("FAIL flush_first: got %h want %h", seen[0], dlog[2][W-1:0]);
    end
    repeat (30) @(negedge clk);
    ks_ready = 1'b0;
  endtask

  task automatic test_init_drop();
    int n;
    int stuck;
    do_reset();
    lat = 6;
    drbg_init_ready = 1'b1;
    for (n = 0; n < 200 && !(exp_q.size() >= 1 && drbg_next_bits); n++) @(negedge clk);
    drbg_init_ready = 1'b0;
    ks_ready = 1'b1;
    stuck = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (drbg_next_bits !== 1'b0) stuck++;
    end
    total += 2;
    if (stuck != 0) begin
      bad++;
      $display("FAIL drop_idle: got %0d cycles requesting want 0", stuck);
    end
    if (seen.size() == 0) begin
      bad++;
      $display("FAIL drop_drain: got %0d slices want >0", seen.size());
    end
    drbg_init_ready = 1'b1;
    for (n = 0; n < 100 && drbg_next_bits !== 1'b1; n++) @(negedge clk);
    total++;
    if (drbg_next_bits !== 1'b1) begin
      bad++;
      $display("FAIL drop_resume: got next_bits=%b want 1", drbg_next_bits);
    end
    repeat (40) @(negedge clk);
    ks_ready = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      ks_ready        = ($urandom % 4) != 0;
      flush           = ($urandom % 97) == 0;
      drbg_init_ready = ($urandom % 40) != 0;
      drbg_busy       = ($urandom % 10) == 0;
      if ($urandom % 50 == 0) lat = $urandom_range(1, 12);
    end
    @(negedge clk);
    flush = 1'b0;
    ks_ready = 1'b0;
    #1;
    total++;
    if (words_consumed !== 32'(exp_consumed)) begin
      bad++;
      $display("FAIL rand_words: got %0d want %0d", words_consumed, exp_consumed);
    end
  endtask

  task automatic test_async_reset();
    int n;
    do_reset();
    lat = 2;
    drbg_init_ready = 1'b1;
    ks_ready = 1'b1;
    for (n = 0; n < 300 && seen.size() < SPW + 3; n++) @(negedge clk);
    ks_ready = 1'b0;
    total++;
    if (seen.size() != SPW + 3) begin
      bad++;
      $display("FAIL ar_setup: got %0d slices want %0d", seen.size(), SPW + 3);
    end
    mon_en = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    total += 4;
    if (ks_valid !== 1'b0) begin bad++; $display("FAIL ar_valid: got %b want 0", ks_valid); end
    if (ks_data !== '0) begin bad++; $display("FAIL ar_data: got %h want 0", ks_data); end
    if (words_consumed !== 32'd0) begin bad++; $display("FAIL ar_words: got %0d want 0", words_consumed); end
    if (drbg_next_bits !== 1'b0) begin bad++; $display("FAIL ar_next_bits: got %b want 0", drbg_next_bits); end
`ifdef KS_UNDERRUN_CNT_EN
    total++;
    if (underrun_cnt !== 16'd0) begin bad++; $display("FAIL ar_underrun: got %0d want 0", underrun_cnt); end
`endif
    do_reset();
    repeat (5) @(negedge clk);
  endtask

  initial begin
    for (int j = 0; j < 32; j++) base_word[j*8 +: 8] = 8'(j);
    test_reset();
    test_byte_pattern();
    test_back_pressure();
    test_latency_gaps();
    test_flush();
    test_init_drop();
    test_random();
    test_async_reset();
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
